// File: rtl/ultrasonido_ranger.sv
// Ultrasonic ranger controller: fires a trigger pulse, times the synchronized
// echo width and converts it to centimetres with a running sub-counter (no divider).
module ultrasonido_ranger #(
    parameter int CM_CYCLES      = 2900,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int HOLDOFF_CYCLES = 3_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        auto_en,
    input  logic        echo,
    output logic        trigger,
    output logic        busy,
    output logic [19:0] echo_cycles,
    output logic [8:0]  distance_cm,
    output logic        valid,
    output logic        timeout
);

    localparam int          SUB_W     = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
    localparam logic [31:0] TRIG_LAST = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HO_LAST   = 32'(HOLDOFF_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CM_CYCLES - 1);
    localparam logic [19:0] CYC_ABORT = 20'hFFFFE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [19:0]      cyc_q, cyc_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [8:0]       cm_q, cm_d;
    logic [19:0]      echo_cycles_q, echo_cycles_d;
    logic [8:0]       distance_q, distance_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             trigger_q, trigger_d;
    logic             busy_q, busy_d;
    logic             echo_meta_q, echo_s_q;
    logic             echo_s;

    logic [19:0]      cyc_inc;
    logic [SUB_W-1:0] sub_inc;
    logic [8:0]       cm_inc;

    assign echo_s = echo_s_q;

    // Two-flop synchronizer for the asynchronous echo pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
        end
    end

    // One echo cycle worth of counting; the cm counter saturates instead of wrapping.
    always_comb begin
        cyc_inc = cyc_q + 20'd1;
        if (sub_q == SUB_LAST) begin
            sub_inc = '0;
            cm_inc  = (cm_q == 9'd511) ? cm_q : (cm_q + 9'd1);
        end else begin
            sub_inc = sub_q + SUB_W'(1);
            cm_inc  = cm_q;
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + 32'd1;
        cyc_d         = cyc_q;
        sub_d         = sub_q;
        cm_d          = cm_q;
        echo_cycles_d = echo_cycles_q;
        distance_d    = distance_q;
        valid_d       = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = 32'd0;
                if (start || auto_en) begin
                    state_d = TRIG;
                    cyc_d   = 20'd0;
                    sub_d   = '0;
                    cm_d    = 9'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    timer_d = 32'd0;
                end else begin
                    state_d = TRIG;
                end
            end
            WAIT_ECHO, MEASURE: begin
                if (echo_s) begin
                    // An echo that would push the cycle counter to all-ones is unmeasurable.
                    if (cyc_q == CYC_ABORT) begin
                        timeout_d = 1'b1;
                        state_d   = HOLDOFF;
                        timer_d   = 32'd0;
                    end else begin
                        state_d = MEASURE;
                        cyc_d   = cyc_inc;
                        sub_d   = sub_inc;
                        cm_d    = cm_inc;
                    end
                end else if (state_q == MEASURE) begin
                    echo_cycles_d = cyc_q;
                    distance_d    = cm_q;
                    valid_d       = 1'b1;
                    state_d       = HOLDOFF;
                    timer_d       = 32'd0;
                end else if (timer_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = HOLDOFF;
                    timer_d   = 32'd0;
                end else begin
                    state_d = WAIT_ECHO;
                end
            end
            HOLDOFF: begin
                if (timer_q == HO_LAST) begin
                    state_d = IDLE;
                    timer_d = 32'd0;
                end else begin
                    state_d = HOLDOFF;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 32'd0;
            end
        endcase
        trigger_d = (state_d == TRIG);
        busy_d    = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= 32'd0;
            cyc_q         <= 20'd0;
            sub_q         <= '0;
            cm_q          <= 9'd0;
            echo_cycles_q <= 20'd0;
            distance_q    <= 9'd0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
            trigger_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cyc_q         <= cyc_d;
            sub_q         <= sub_d;
            cm_q          <= cm_d;
            echo_cycles_q <= echo_cycles_d;
            distance_q    <= distance_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
            trigger_q     <= trigger_d;
            busy_q        <= busy_d;
        end
    end

    assign trigger     = trigger_q;
    assign busy        = busy_q;
    assign echo_cycles = echo_cycles_q;
    assign distance_cm = distance_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: doc/ultrasonido_ranger.md
ULTRASONIDO_RANGER -- requirements
Module: ultrasonido_ranger

Interface
REQ-001 Parameter CM_CYCLES, 2900, clk cycles of echo per centimetre (58 us at 50 MHz).
REQ-002 Parameter TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us).
REQ-003 Parameter TIMEOUT_CYCLES, 1_000_000, maximum wait for echo rise after trigger fall.
REQ-004 Parameter HOLDOFF_CYCLES, 3_000_000, dead time after each measurement before next trigger.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  request one measurement; sampled only in IDLE.
REQ-008 auto_en  input  1  when 1, IDLE starts a new measurement without start.
REQ-009 echo  input  1  asynchronous sensor echo pin.
REQ-010 trigger  output  1  registered sensor trigger pin.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 echo_cycles  output  20  last measured echo width in clk cycles.
REQ-013 distance_cm  output  9  last measured distance in cm.
REQ-014 valid  output  1  one-cycle pulse: echo_cycles/distance_cm updated.
REQ-015 timeout  output  1  one-cycle pulse: measurement aborted.

Function
REQ-016 echo SHALL pass through a 2-flop synchronizer (echo_s); all decisions use echo_s only.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-018 IDLE: if start=1 or auto_en=1, go to TRIG next cycle; otherwise stay.
REQ-019 TRIG: trigger=1 for exactly TRIG_CYCLES consecutive cycles, then WAIT_ECHO with trigger=0.
REQ-020 WAIT_ECHO: echo_s=1 -> MEASURE; after TIMEOUT_CYCLES cycles with echo_s=0 -> timeout pulse, HOLDOFF.
REQ-021 MEASURE: each cycle with echo_s=1 increments 20-bit cycle counter and a CM_CYCLES sub-counter; sub-counter wrap increments 9-bit cm counter.
REQ-022 Width: echo_cycles = count of cycles echo_s sampled 1; distance_cm = floor(echo_cycles / CM_CYCLES); no divider.
REQ-023 cm counter SHALL saturate at 511; cycle counter reaching 20'hFFFFF SHALL abort: timeout pulse, HOLDOFF, outputs unchanged.
REQ-024 First cycle of echo_s=0 in MEASURE: latch echo_cycles/distance_cm, valid=1 next cycle, go HOLDOFF.
REQ-025 valid and timeout SHALL never be high in the same cycle; each high exactly one cycle.
REQ-026 echo_cycles/distance_cm SHALL hold last valid result until next valid; timeout leaves them unchanged.
REQ-027 HOLDOFF: wait HOLDOFF_CYCLES cycles ignoring echo_s and start, then IDLE.
REQ-028 start pulses outside IDLE SHALL be dropped, not queued.
REQ-029 echo_s already high on WAIT_ECHO entry SHALL be measured from that cycle (no edge requirement).

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, trigger=0, busy=0, valid=0, timeout=0, echo_cycles=0, distance_cm=0, all counters and synchronizer to 0.
REQ-031 rst_n deasserted mid-measurement SHALL not produce valid or timeout; block restarts in IDLE.

Verification (CM_CYCLES=10, TRIG_CYCLES=5, TIMEOUT_CYCLES=50, HOLDOFF_CYCLES=20)
REQ-032 start 1 cycle, echo high 37 cycles after trigger -> trigger high 5 cycles, valid once, echo_cycles=37, distance_cm=3.
REQ-033 start, echo never rises -> timeout once 50 cycles after trigger fall, valid never, outputs keep prior values.
REQ-034 auto_en=1, echo 25 then 60 cycles -> two triggers separated by HOLDOFF, results 25/2 then 60/6.
REQ-035 echo high 9 cycles -> distance_cm=0, echo_cycles=9; echo 10 cycles -> distance_cm=1.
REQ-036 rst_n low during MEASURE -> outputs 0 asynchronously, no valid, trigger=0, busy=0.
REQ-037 start asserted during HOLDOFF with auto_en=0 -> no further trigger; busy falls after HOLDOFF.
